// File: rtl/kernel_eval_linear.sv
// Linear-kernel evaluator: streams a pixel vector against NUM_OF_SV support vectors
// in parallel and emits sign-magnitude 8.8 kernel values once the vector is consumed.
module kernel_eval_linear #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 784,
  parameter int NUM_OF_SV     = 10,
  parameter int ACC_W         = 26,
  parameter int ADDR_W        = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [XLEN_PIXEL-1:0]             pixel_in,
  input  logic                              pixel_valid,
  output logic                              pixel_ready,
  output logic [ADDR_W-1:0]                 sv_addr,
  input  logic [NUM_OF_SV*XLEN_PIXEL-1:0]   sv_data,
  output logic [2*XLEN_PIXEL*NUM_OF_SV-1:0] kernel_out,
  output logic                              kernel_valid,
  output logic                              busy
);

  localparam int KW      = 2 * XLEN_PIXEL;
  localparam int MW      = XLEN_PIXEL - 1;
  localparam int MAG_MAX = 2 ** (KW - 1) - 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OF_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CONV, DONE} state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [ADDR_W-1:0]            cnt;
  logic [XLEN_PIXEL-1:0]        pix_q;
  logic                         tag_v;
  logic [ACC_W-1:0]             acc      [NUM_OF_SV];
  logic [ACC_W-1:0]             prod     [NUM_OF_SV];
  logic                         sv_neg   [NUM_OF_SV];
  logic [KW*NUM_OF_SV-1:0]      kern_nxt;
  logic                         beat;
  logic                         start_acc;

  // Handshake: a pixel transfers on any cycle with pixel_valid && pixel_ready;
  // pixel_ready is high only in RUN, so pixel inputs are ignored elsewhere.
  assign pixel_ready = (state == RUN);
  assign beat        = pixel_valid && pixel_ready;
  assign start_acc   = start && ((state == IDLE) || (state == DONE));
  assign busy        = (state == RUN) || (state == DRAIN) || (state == CONV);
  assign sv_addr     = cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (beat && (cnt == LAST)) state_nxt = DRAIN;
      DRAIN:   state_nxt = CONV;
      CONV:    state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Q0.15 product per SV; the sign bit of each ROM element picks add or subtract.
  always_comb begin
    for (int i = 0; i < NUM_OF_SV; i++) begin
      prod[i]   = ACC_W'(pix_q) * ACC_W'(sv_data[i*XLEN_PIXEL +: MW]);
      sv_neg[i] = sv_data[i*XLEN_PIXEL + MW];
    end
  end

  // Two's complement accumulator to sign-magnitude 8.8, saturating, never negative zero.
  function automatic logic [KW-1:0] to_fixed(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] mag_abs;
    logic [ACC_W-1:0] mag_sh;
    logic [KW-2:0]    mag;
    mag_abs = a[ACC_W-1] ? (~a + ACC_W'(1)) : a;
    mag_sh  = mag_abs >> MW;
    mag     = (mag_sh > ACC_W'(MAG_MAX)) ? '1 : mag_sh[KW-2:0];
    return {a[ACC_W-1] && (mag != '0), mag};
  endfunction

  always_comb begin
    kern_nxt = '0;
    for (int i = 0; i < NUM_OF_SV; i++) begin
      kern_nxt[i*KW +: KW] = to_fixed(acc[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pix_q        <= '0;
      tag_v        <= 1'b0;
      kernel_out   <= '0;
      kernel_valid <= 1'b0;
      for (int i = 0; i < NUM_OF_SV; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      tag_v <= beat;
      if (beat) begin
        pix_q <= pixel_in;
        cnt   <= cnt + ADDR_W'(1);
      end
      // The tagged pixel meets its ROM word one cycle after acceptance.
      if (start_acc) begin
        cnt          <= '0;
        kernel_valid <= 1'b0;
        for (int i = 0; i < NUM_OF_SV; i++) acc[i] <= '0;
      end else if (tag_v) begin
        for (int i = 0; i < NUM_OF_SV; i++) begin
          acc[i] <= sv_neg[i] ? (acc[i] - prod[i]) : (acc[i] + prod[i]);
        end
      end
      if (state == CONV) begin
        kernel_out   <= kern_nxt;
        kernel_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kernel_eval_linear.sv
// Bench for kernel_eval_linear: a 4-pixel/2-SV instance for directed and random runs,
// and a default-parameter instance for saturation and a full-length random vector.
module tb_kernel_eval_linear;
  localparam int SN  = 4;
  localparam int SSV = 2;
  localparam int BN  = 784;
  localparam int BSV = 10;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_s = 1'b0, pv_s = 1'b0;
  logic [7:0]  pix_s   = '0;
  logic        ready_s, kv_s, busy_s;
  logic [9:0]  addr_s;
  logic [15:0] svd_s;
  logic [31:0] ko_s;

  logic         start_b = 1'b0, pv_b = 1'b0;
  logic [7:0]   pix_b   = '0;
  logic         ready_b, kv_b, busy_b;
  logic [9:0]   addr_b;
  logic [79:0]  svd_b;
  logic [159:0] ko_b;

  logic [7:0]   m_pix [1024];
  logic [7:0]   m_sv  [10][1024];
  logic [159:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  kernel_eval_linear #(.NUM_OF_PIXELS(SN), .NUM_OF_SV(SSV)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .pixel_in(pix_s), .pixel_valid(pv_s),
    .pixel_ready(ready_s), .sv_addr(addr_s), .sv_data(svd_s), .kernel_out(ko_s),
    .kernel_valid(kv_s), .busy(busy_s)
  );

  kernel_eval_linear u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pixel_in(pix_b), .pixel_valid(pv_b),
    .pixel_ready(ready_b), .sv_addr(addr_b), .sv_data(svd_b), .kernel_out(ko_b),
    .kernel_valid(kv_b), .busy(busy_b)
  );

  // SV ROMs with one-cycle registered read
  always @(posedge clk) begin
    for (int i = 0; i < SSV; i++) svd_s[i*8 +: 8] <= m_sv[i][addr_s];
    for (int i = 0; i < BSV; i++) svd_b[i*8 +: 8] <= m_sv[i][addr_b];
  end

  // reference model: signed dot product, then 8.8 sign-magnitude with saturation
  function automatic logic [159:0] model(input int n, input int nsv);
    logic [159:0] r;
    longint s, p, a, mag;
    r = '0;
    for (int i = 0; i < nsv; i++) begin
      s = 0;
      for (int j = 0; j < n; j++) begin
        p = longint'(m_pix[j]) * longint'(m_sv[i][j][6:0]);
        s = m_sv[i][j][7] ? s - p : s + p;
      end
      a   = (s < 0) ? -s : s;
      mag = a / 128;
      if (mag > 32767) mag = 32767;
      r[i*16 +: 16] = {(s < 0) && (mag != 0), mag[14:0]};
    end
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill_uniform(input logic [7:0] p, input logic [7:0] sv_even, input logic [7:0] sv_odd);
    for (int j = 0; j < 1024; j++) begin
      m_pix[j] = p;
      for (int i = 0; i < 10; i++) m_sv[i][j] = (i % 2 == 0) ? sv_even : sv_odd;
    end
  endtask

  task automatic fill_random;
    for (int j = 0; j < 1024; j++) begin
      m_pix[j] = 8'($urandom);
      for (int i = 0; i < 10; i++) m_sv[i][j] = 8'($urandom);
    end
  endtask

  // driver: one evaluation on the small instance, optional stall and stray start pulses
  task automatic run_small(input string tag, input int stall_at, input int stall_len,
                           input logic [63:0] start_mask);
    int   cyc, j, sc;
    logic acc_beat;
    exp_q.push_back(model(SN, SSV));
    start_s = 1'b1;
    step;
    start_s = 1'b0;
    check({tag, "/kv_clr_busy"}, {158'd0, kv_s, busy_s}, 160'd1);
    cyc = 1; j = 0; sc = 0;
    while (!kv_s && cyc < 60) begin
      start_s = start_mask[cyc];
      if (j < SN && j == stall_at && sc < stall_len) begin
        pv_s  = 1'b0;
        pix_s = 8'($urandom);
        sc++;
        check({tag, "/addr_hold"}, 160'(addr_s), 160'(j));
      end else begin
        pv_s  = (j < SN);
        pix_s = (j < SN) ? m_pix[j] : 8'($urandom);
      end
      acc_beat = pv_s && ready_s;
      step;
      cyc++;
      if (acc_beat) j++;
    end
    start_s = 1'b0;
    pv_s    = 1'b0;
    check({tag, "/latency"}, 160'(cyc), 160'(SN + 3 + stall_len));
    check({tag, "/kernel"}, 160'(ko_s), exp_q.pop_front());
  endtask

  task automatic done_hold(input string tag, input logic [159:0] exp_k);
    for (int k = 0; k < 5; k++) begin
      pv_s  = 1'b1;
      pix_s = 8'($urandom);
      step;
      check(tag, {ko_s, kv_s, busy_s, ready_s}, {exp_k[31:0], 1'b1, 1'b0, 1'b0});
    end
    pv_s = 1'b0;
  endtask

  task automatic reset_abort;
    start_s = 1'b1;
    step;
    start_s = 1'b0;
    pv_s = 1'b1;
    pix_s = m_pix[0];
    step;
    pix_s = m_pix[1];
    step;
    pv_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort/outputs_zero", {ko_s, kv_s, ready_s, busy_s, addr_s}, 160'd0);
    step;
    step;
    rst_n = 1'b1;
    step;
    step;
    check("abort/idle_wait", {busy_s, ready_s, kv_s, addr_s}, 160'd0);
  endtask

  task automatic run_big(input string tag);
    int   cyc, j;
    logic acc_beat;
    exp_q.push_back(model(BN, BSV));
    start_b = 1'b1;
    step;
    start_b = 1'b0;
    cyc = 1; j = 0;
    while (!kv_b && cyc < 900) begin
      pv_b  = (j < BN);
      pix_b = m_pix[j];
      acc_beat = pv_b && ready_b;
      step;
      cyc++;
      if (acc_beat) j++;
    end
    pv_b = 1'b0;
    check({tag, "/latency"}, 160'(cyc), 160'(BN + 3));
    check({tag, "/kernel"}, ko_b, exp_q.pop_front());
  endtask

  initial begin
    fill_uniform(8'h00, 8'h00, 8'h00);
    rst_n = 1'b0;
    step;
    step;
    check("reset/small", {ko_s, kv_s, ready_s, busy_s, addr_s}, 160'd0);
    check("reset/big", {ko_b, kv_b, ready_b, busy_b}, 160'd0);
    check("reset/big_addr", 160'(addr_b), 160'd0);
    rst_n = 1'b1;
    step;

    fill_uniform(8'h80, 8'h40, 8'hC0);
    run_small("basic", -1, 0, 64'd0);
    run_small("stall", 2, 3, 64'd0);
    run_small("ignore_start", -1, 0, 64'h64);
    done_hold("done_ignore", model(SN, SSV));

    for (int j = 0; j < 1024; j++) m_sv[0][j] = j[0] ? 8'hC0 : 8'h40;
    run_small("neg_zero", -1, 0, 64'd0);

    fill_uniform(8'h80, 8'h40, 8'hC0);
    reset_abort;
    run_small("post_reset", -1, 0, 64'd0);

    for (int r = 0; r < 8; r++) begin
      fill_random;
      run_small($sformatf("rand%0d", r), $urandom_range(0, 3), $urandom_range(0, 3), 64'd0);
    end

    fill_uniform(8'hFF, 8'h7F, 8'h7F);
    run_big("sat_pos");
    fill_uniform(8'hFF, 8'hFF, 8'hFF);
    run_big("sat_neg");
    fill_random;
    run_big("rand_big");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
